// File: rtl/usb_nrzi_encoder.sv
// NRZI line encoder and SE0-SE0-J end-of-packet generator for the USB transmitter.
// Define USB_NRZI_LOW_SPEED_EN for low-speed polarity (J = D-); default is full speed.
module usb_nrzi_encoder (
  input  logic clk,
  input  logic n_rst,
  input  logic send_next_bit,
  input  logic Tim_en,
  input  logic raw_to_encoder,
  input  logic eop_req,
  output logic d_plus,
  output logic d_minus,
  output logic tx_active,
  output logic eop_done
);

`ifdef USB_NRZI_LOW_SPEED_EN
  localparam logic J_DP = 1'b0;
  localparam logic J_DM = 1'b1;
`else
  localparam logic J_DP = 1'b1;
  localparam logic J_DM = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    EOP_SE0_A,
    EOP_SE0_B,
    EOP_J
  } state_t;

  state_t state;
  logic   level_j;   // 1 = line currently at J, 0 = at K
  logic   data_j;

  // A 1 keeps the current level, a 0 toggles it.
  assign data_j = raw_to_encoder ? level_j : ~level_j;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      level_j   <= 1'b1;
      d_plus    <= J_DP;
      d_minus   <= J_DM;
      tx_active <= 1'b0;
      eop_done  <= 1'b0;
    end else begin
      eop_done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_next_bit && Tim_en && !eop_req) begin
            state     <= DATA;
            level_j   <= raw_to_encoder;
            d_plus    <= raw_to_encoder ? J_DP : ~J_DP;
            d_minus   <= raw_to_encoder ? J_DM : ~J_DM;
            tx_active <= 1'b1;
          end
        end
        DATA: begin
          // Losing the enable aborts the packet without an EOP, even mid-strobe.
          if (!Tim_en) begin
            state     <= IDLE;
            level_j   <= 1'b1;
            d_plus    <= J_DP;
            d_minus   <= J_DM;
            tx_active <= 1'b0;
          end else if (send_next_bit) begin
            if (eop_req) begin
              state   <= EOP_SE0_A;
              d_plus  <= 1'b0;
              d_minus <= 1'b0;
            end else begin
              level_j <= data_j;
              d_plus  <= data_j ? J_DP : ~J_DP;
              d_minus <= data_j ? J_DM : ~J_DM;
            end
          end
        end
        EOP_SE0_A: begin
          if (send_next_bit) begin
            state <= EOP_SE0_B;
          end
        end
        EOP_SE0_B: begin
          if (send_next_bit) begin
            state   <= EOP_J;
            level_j <= 1'b1;
            d_plus  <= J_DP;
            d_minus <= J_DM;
          end
        end
        EOP_J: begin
          if (send_next_bit) begin
            state     <= IDLE;
            level_j   <= 1'b1;
            tx_active <= 1'b0;
            eop_done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          level_j   <= 1'b1;
          d_plus    <= J_DP;
          d_minus   <= J_DM;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_nrzi_encoder.sv
// Self-checking bench for usb_nrzi_encoder: directed packets plus randomized packets
// checked against a line-level model of NRZI and the SE0-SE0-J end of packet.
module tb_usb_nrzi_encoder;

`ifdef USB_NRZI_LOW_SPEED_EN
  localparam logic [1:0] LJ = 2'b01;
  localparam logic [1:0] LK = 2'b10;
`else
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
`endif
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst;
  logic send_next_bit;
  logic Tim_en;
  logic raw_to_encoder;
  logic eop_req;
  logic d_plus;
  logic d_minus;
  logic tx_active;
  logic eop_done;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_line;
  logic       exp_act;
  logic       pkt [0:63];

  usb_nrzi_encoder dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .send_next_bit  (send_next_bit),
    .Tim_en         (Tim_en),
    .raw_to_encoder (raw_to_encoder),
    .eop_req        (eop_req),
    .d_plus         (d_plus),
    .d_minus        (d_minus),
    .tx_active      (tx_active),
    .eop_done       (eop_done)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
  task automatic applyStimulus(input logic s, input logic t, input logic r, input logic e);
    send_next_bit  = s;
    Tim_en         = t;
    raw_to_encoder = r;
    eop_req        = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] line, input logic act,
                             input logic done);
    checks++;
    assert ({d_plus, d_minus} === line) else begin
      errors++;
      $error("[TB] FAIL %s line got %b expected %b", tag, {d_plus, d_minus}, line);
    end
    checks++;
    assert (tx_active === act) else begin
      errors++;
      $error("[TB] FAIL %s tx_active got %b expected %b", tag, tx_active, act);
    end
    checks++;
    assert (eop_done === done) else begin
      errors++;
      $error("[TB] FAIL %s eop_done got %b expected %b", tag, eop_done, done);
    end
  endtask

  // Cycles without a strobe: every output must hold.
  task automatic gapCycles(input int n, input logic ten);
    for (int g = 0; g < n; g++) begin
      applyStimulus(1'b0, ten, 1'($urandom % 2), 1'($urandom % 2));
      checkOutput("hold", exp_line, exp_act, 1'b0);
    end
  endtask

  // Sends pkt[0..n-1] then a full EOP; line expectations come from the NRZI rule.
  task automatic runPacket(input int n, input int max_gap, input logic drop_ten);
    logic ten;
    exp_line = LJ;
    exp_act  = 1'b0;
    gapCycles(int'($urandom_range(0, max_gap)), 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) gapCycles(int'($urandom_range(0, max_gap)), 1'b1);
      if (pkt[i] == 1'b0) exp_line = (exp_line == LJ) ? LK : LJ;
      exp_act = 1'b1;
      applyStimulus(1'b1, 1'b1, pkt[i], 1'b0);
      checkOutput("data", exp_line, 1'b1, 1'b0);
    end
    gapCycles(int'($urandom_range(0, max_gap)), 1'b1);
    applyStimulus(1'b1, 1'b1, 1'($urandom % 2), 1'b1);
    exp_line = LSE0;
    checkOutput("eop_se0_a", LSE0, 1'b1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      ten = drop_ten ? 1'b0 : 1'($urandom % 2);
      gapCycles(int'($urandom_range(0, max_gap)), ten);
      applyStimulus(1'b1, ten, 1'($urandom % 2), 1'($urandom % 2));
      if (s == 0) begin
        checkOutput("eop_se0_b", LSE0, 1'b1, 1'b0);
      end else if (s == 1) begin
        exp_line = LJ;
        checkOutput("eop_j", LJ, 1'b1, 1'b0);
      end else begin
        exp_act = 1'b0;
        checkOutput("eop_done", LJ, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    int n;
    n_rst          = 1'b0;
    send_next_bit  = 1'b0;
    Tim_en         = 1'b0;
    raw_to_encoder = 1'b0;
    eop_req        = 1'b0;
    exp_line       = LJ;
    exp_act        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", LJ, 1'b0, 1'b0);
    n_rst = 1'b1;
    gapCycles(4, 1'b0);

    // IDLE ignores eop_req and strobes without Tim_en.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("idle_eopreq", LJ, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_noen", LJ, 1'b0, 1'b0);

    $display("[TB] SYNC + stuffed run + EOP");
    for (int i = 0; i < 7; i++) pkt[i] = 1'b0;
    pkt[7] = 1'b1;
    for (int i = 8; i < 14; i++) pkt[i] = 1'b1;
    pkt[14] = 1'b0;
    runPacket(15, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_eop", LJ, 1'b0, 1'b0);

    $display("[TB] abort on Tim_en low at K");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_k", LK, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_j", LJ, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_idle", LJ, 1'b0, 1'b0);

    $display("[TB] Tim_en dropped during EOP");
    pkt[0] = 1'b0; pkt[1] = 1'b1; pkt[2] = 1'b0;
    runPacket(3, 1, 1'b1);

    $display("[TB] reset during EOP_SE0_B");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_data", LK, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_se0a", LSE0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_se0b", LSE0, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("rst_async", LJ, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_held", LJ, 1'b0, 1'b0);
    #2 n_rst = 1'b1;
    exp_line = LJ;
    exp_act  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_no_done", LJ, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_next_k", LK, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_next_abort", LJ, 1'b0, 1'b0);

    $display("[TB] randomized packets");
    for (int p = 0; p < 30; p++) begin
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) pkt[i] = 1'($urandom % 2);
      runPacket(n, (p % 3 == 0) ? 0 : 2, 1'($urandom % 2));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("final_idle", LJ, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_nrzi_encoder.md
# usb_nrzi_encoder

Transmit-side NRZI line encoder and end-of-packet generator for the USB transmitter module. It consumes the stuffed serial bit stream from `bit_stuff` (`raw_to_encoder`) on each bit-period strobe (`send_next_bit`) and drives the differential bus pair. It also generates the SE0-SE0-J end-of-packet sequence and holds the idle J state between packets.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `send_next_bit`  in  1  one-cycle bit-period strobe from the USB timer; same strobe `bit_stuff` uses
- `Tim_en`  in  1  transmission enable; high for the whole packet
- `raw_to_encoder`  in  1  stuffed data bit from `bit_stuff`; valid whenever `send_next_bit`=1
- `eop_req`  in  1  level; tells the encoder the last data bit has been sent and to start EOP
- `d_plus`  out  1  registered D+ line drive
- `d_minus`  out  1  registered D- line drive
- `tx_active`  out  1  high while in DATA or any EOP state
- `eop_done`  out  1  one-cycle pulse when EOP completes

## Operation
- Line states (full speed): J = (D+,D-)=(1,0); K = (0,1); SE0 = (0,0).
- NRZI rule: bit 1 holds the current level; bit 0 toggles J<->K.
- FSM states: IDLE, DATA, EOP_SE0_A, EOP_SE0_B, EOP_J.
- "Strobe" means `send_next_bit`=1 at a rising edge of `clk`.
- IDLE:
  - drives J; `tx_active`=0.
  - On strobe with `Tim_en`=1 and `eop_req`=0: go to DATA and encode `raw_to_encoder` against J. A first bit of 0 gives K.
- DATA:
  - On strobe with `eop_req`=0: encode `raw_to_encoder` against the current level.
  - On strobe with `eop_req`=1: go to EOP_SE0_A and drive SE0. `raw_to_encoder` is ignored; `eop_req` has priority over a data bit in the same strobe.
  - `Tim_en`=0 at any edge: abort to IDLE and drive J at that edge. No EOP and no `eop_done`.
- EOP_SE0_A: on strobe, go to EOP_SE0_B; SE0 is held.
- EOP_SE0_B: on strobe, go to EOP_J and drive J.
- EOP_J: on strobe, go to IDLE and pulse `eop_done` for that one cycle.
- EOP states ignore `Tim_en`, `eop_req` and `raw_to_encoder`. An EOP always completes once started.
- `eop_req` in IDLE is ignored.
- Between strobes all outputs hold.
- The NRZI level register holds the last J/K level. It is forced to J on entry to IDLE and on entry to EOP_J.

## Timing
- Reset values: state=IDLE, `d_plus`=1, `d_minus`=0, `tx_active`=0, `eop_done`=0, NRZI level=J.
- Outputs are all flops. There is no combinational path from any input to any output.
- Latency: a line state is driven starting at the clock edge that samples its strobe.
- Each bit occupies exactly one strobe interval.
- EOP timing:
  - SE0 lasts exactly 2 bit periods.
  - J lasts exactly 1 bit period.
  - `eop_done` rises at the strobe that ends EOP_J, lasts one `clk` cycle, and coincides with `tx_active` falling.
- Reset asserted mid-packet, including mid-EOP: outputs return to reset values immediately (asynchronously). No `eop_done`.
- A new packet may start on the strobe immediately after `eop_done`.

## Configuration
- `USB_NRZI_LOW_SPEED_EN` defined: low-speed polarity, J = (0,1) and K = (1,0). Reset and idle drive `d_plus`=0, `d_minus`=1.
- `USB_NRZI_LOW_SPEED_EN` undefined: full-speed polarity as above. SE0 and all timing are identical in both builds.

## Test plan
- Reset, then no strobes: `d_plus`=1, `d_minus`=0, `tx_active`=0, `eop_done`=0 held.
- `Tim_en`=1 with 8 strobes of bits 0,0,0,0,0,0,0,1 (SYNC): line sequence K,J,K,J,K,J,K,K; `tx_active` goes to 1 at the first strobe.
- After SYNC, bits 1,1,1,1,1,1,0 (stuffed 0 from `bit_stuff`): line holds K for six periods, then toggles to J.
- `eop_req`=1 at the next strobe with `raw_to_encoder`=0:
  - line goes SE0 for 2 strobes, then J for 1 strobe;
  - `eop_done` is a single-cycle pulse at the 4th strobe;
  - `tx_active` is 0 afterwards.
- `Tim_en` dropped mid-DATA while the line is at K: line goes to J at the next edge, `tx_active`=0, no `eop_done`. `Tim_en` dropped during EOP_SE0_A: EOP still completes.
- `n_rst` pulsed low during EOP_SE0_B: line goes to J immediately, no `eop_done`. The next packet's first bit 0 gives K.
